// File: rtl/fpu_pkg.sv
// Shared FP datapath constants: default field widths, bias, packed-field slices
// and the guard/round/sticky width used by the alignment logic.
package fpu_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int BIAS     = (1 << (FP_EXP_W - 1)) - 1;
    localparam int SIGN_BIT = FP_EXP_W + FP_MAN_W;
    localparam int EXP_HI   = SIGN_BIT - 1;
    localparam int EXP_LO   = FP_MAN_W;
    localparam int FRAC_HI  = FP_MAN_W - 1;
    localparam int FRAC_LO  = 0;
    localparam int GRS_W    = 3;
endpackage

// File: rtl/fadd_align_stage_if.sv
// Operand/result bundle of the FP add alignment stage.
// Both sides are valid/ready: a transfer happens on a rising edge where valid and
// ready are both high; the sender holds its payload stable while valid & !ready.
interface fadd_align_stage_if
    import fpu_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic [EXP_W+MAN_W:0]     x;
    logic [EXP_W+MAN_W:0]     y;
    logic                     op;
    logic                     out_valid;
    logic                     out_ready;
    logic                     Sx;
    logic                     Sy;
    logic                     EOP;
    logic                     cmp;
    logic                     zero_d;
    logic                     sign_d;
    logic [EXP_W-1:0]         e_big;
    logic [MAN_W:0]           m_big;
    logic [MAN_W+GRS_W:0]     m_small;
    logic                     is_nan;
    logic                     is_inf;

    modport master (
        output in_valid, x, y, op, out_ready,
        input  in_ready, out_valid, Sx, Sy, EOP, cmp, zero_d, sign_d,
               e_big, m_big, m_small, is_nan, is_inf
    );

    modport slave (
        input  in_valid, x, y, op, out_ready,
        output in_ready, out_valid, Sx, Sy, EOP, cmp, zero_d, sign_d,
               e_big, m_big, m_small, is_nan, is_inf
    );
endinterface

// File: rtl/fpu_align_shifter.sv
// Right shift that collapses every shifted-out bit into a sticky bit at bit 0.
// Shift amounts of W-1 or more leave only the sticky of the whole input.
module fpu_align_shifter #(
    parameter int W    = 27,
    parameter int SH_W = $clog2(W)
) (
    input  logic [W-1:0]    data,
    input  logic [SH_W-1:0] shamt,
    output logic [W-1:0]    result
);
    localparam logic [SH_W-1:0] SAT = SH_W'(W - 1);

    logic [W-1:0] shifted;
    logic [W-1:0] lost_mask;

    always_comb begin
        shifted   = data >> shamt;
        lost_mask = ~({W{1'b1}} << shamt);
        result    = shifted;
        if (shamt >= SAT) begin
            result    = '0;
            result[0] = |data;
        end else begin
            result[0] = shifted[0] | (|(data & lost_mask));
        end
    end
endmodule

// File: rtl/fadd_align_stage.sv
// Two-stage FP add/sub front end: stage 1 unpacks, compares and swaps operands,
// stage 2 aligns the smaller significand with guard/round/sticky bits.
module fadd_align_stage
    import fpu_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input logic              clk,
    input logic              rst_n,
    fadd_align_stage_if.slave bus
);
    localparam int SIG_W = MAN_W + 1;
    localparam int AL_W  = SIG_W + GRS_W;
    localparam int SH_W  = $clog2(AL_W);
    localparam int S_BIT = EXP_W + MAN_W;
    localparam logic [EXP_W:0] SH_SAT = (EXP_W + 1)'(AL_W - 1);

    logic [EXP_W-1:0] ex, ey, eex, eey;
    logic [MAN_W-1:0] fx, fy;
    logic [SIG_W-1:0] mx, my;
    logic [EXP_W:0]   d, abs_d;
    logic             sy_eff, eop_c, zd, sd, cm, swp;
    logic             x_inf, x_nan, y_inf, y_nan, nan_c, inf_c;
    logic [SH_W-1:0]  shamt_c;

    // Denormals and zeros share the effective exponent 1 with no hidden bit.
    assign ex     = bus.x[S_BIT-1 -: EXP_W];
    assign ey     = bus.y[S_BIT-1 -: EXP_W];
    assign fx     = bus.x[MAN_W-1:0];
    assign fy     = bus.y[MAN_W-1:0];
    assign eex    = (ex != '0) ? ex : EXP_W'(1);
    assign eey    = (ey != '0) ? ey : EXP_W'(1);
    assign mx     = {ex != '0, fx};
    assign my     = {ey != '0, fy};
    assign sy_eff = bus.y[S_BIT] ^ bus.op;
    assign eop_c  = bus.x[S_BIT] ^ sy_eff;

    assign d       = {1'b0, eex} - {1'b0, eey};
    assign zd      = (d == '0);
    assign sd      = d[EXP_W];
    assign cm      = (mx < my);
    assign swp     = sd | (zd & cm);
    assign abs_d   = sd ? -d : d;
    assign shamt_c = (abs_d >= SH_SAT) ? SH_SAT[SH_W-1:0] : abs_d[SH_W-1:0];

    assign x_inf = (&ex) & ~(|fx);
    assign x_nan = (&ex) & (|fx);
    assign y_inf = (&ey) & ~(|fy);
    assign y_nan = (&ey) & (|fy);
    assign nan_c = x_nan | y_nan | (x_inf & y_inf & eop_c);
    assign inf_c = (x_inf | y_inf) & ~nan_c;

    logic             v1, v2, adv2, take;
    logic             s1_sx, s1_sy, s1_eop, s1_cmp, s1_zd, s1_sd, s1_nan, s1_inf;
    logic [EXP_W-1:0] s1_e_big;
    logic [SIG_W-1:0] s1_m_big, s1_m_small;
    logic [SH_W-1:0]  s1_shamt;
    logic [AL_W-1:0]  aligned;

    assign adv2          = ~v2 | bus.out_ready;
    assign bus.in_ready  = ~v1 | adv2;
    assign bus.out_valid = v2;
    assign take          = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_sx      <= 1'b0;
            s1_sy      <= 1'b0;
            s1_eop     <= 1'b0;
            s1_cmp     <= 1'b0;
            s1_zd      <= 1'b0;
            s1_sd      <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_e_big   <= '0;
            s1_m_big   <= '0;
            s1_m_small <= '0;
            s1_shamt   <= '0;
        end else begin
            if (bus.in_ready) v1 <= bus.in_valid;
            if (take) begin
                s1_sx      <= bus.x[S_BIT];
                s1_sy      <= sy_eff;
                s1_eop     <= eop_c;
                s1_cmp     <= cm;
                s1_zd      <= zd;
                s1_sd      <= sd;
                s1_nan     <= nan_c;
                s1_inf     <= inf_c;
                s1_e_big   <= swp ? eey : eex;
                s1_m_big   <= swp ? my : mx;
                s1_m_small <= swp ? mx : my;
                s1_shamt   <= shamt_c;
            end
        end
    end

    fpu_align_shifter #(.W(AL_W), .SH_W(SH_W)) u_shift (
        .data   ({s1_m_small, {GRS_W{1'b0}}}),
        .shamt  (s1_shamt),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2          <= 1'b0;
            bus.Sx      <= 1'b0;
            bus.Sy      <= 1'b0;
            bus.EOP     <= 1'b0;
            bus.cmp     <= 1'b0;
            bus.zero_d  <= 1'b0;
            bus.sign_d  <= 1'b0;
            bus.is_nan  <= 1'b0;
            bus.is_inf  <= 1'b0;
            bus.e_big   <= '0;
            bus.m_big   <= '0;
            bus.m_small <= '0;
        end else begin
            if (adv2) v2 <= v1;
            if (v1 && adv2) begin
                bus.Sx      <= s1_sx;
                bus.Sy      <= s1_sy;
                bus.EOP     <= s1_eop;
                bus.cmp     <= s1_cmp;
                bus.zero_d  <= s1_zd;
                bus.sign_d  <= s1_sd;
                bus.is_nan  <= s1_nan;
                bus.is_inf  <= s1_inf;
                bus.e_big   <= s1_e_big;
                bus.m_big   <= s1_m_big;
                bus.m_small <= aligned;
            end
        end
    end
endmodule

// File: doc/fadd_align_stage.md
Name: fadd_align_stage

Overview:
- Two-stage pipelined front end of the FP add/sub datapath; sits directly upstream of the result-sign selector and the mantissa adder.
- Unpacks X and Y, forms the effective operation, and compares exponents and mantissas.
- Emits the decision flags Sx, Sy, EOP, cmp, zero_d, sign_d, plus the larger exponent and the swapped/aligned mantissas with guard/round/sticky bits.
- Valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width (hidden bit excluded).

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept.
- x  in  1+EXP_W+MAN_W  operand X, IEEE packed.
- y  in  1+EXP_W+MAN_W  operand Y, IEEE packed.
- op  in  1  0 = add, 1 = subtract (X - Y).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- Sx  out  1  sign of X.
- Sy  out  1  sign of Y after op applied (y[sign]^op).
- EOP  out  1  1 = effective subtraction (Sx^Sy).
- cmp  out  1  1 when Mx < My (full significands incl. hidden bit).
- zero_d  out  1  1 when Ex == Ey.
- sign_d  out  1  1 when Ex < Ey.
- e_big  out  EXP_W  larger effective exponent.
- m_big  out  MAN_W+1  significand of larger-magnitude operand.
- m_small  out  MAN_W+4  smaller significand aligned: {hidden, frac, G, R, S}.
- is_nan  out  1  either operand NaN, or inf - inf under effective subtraction.
- is_inf  out  1  result infinite (and not is_nan).

Behaviour:
- Reset (rst_n low, async): both stage valid flags = 0; all data outputs = 0; out_valid = 0. in_ready follows combinationally from stage-1 occupancy.
- Unpack: hidden bit = (exp != 0).
  - Effective exponent = 1 when exp == 0 (denormal); otherwise exp.
  - Zeros are handled as denormals with a zero fraction.
- Stage 1, captured when in_valid & in_ready:
  - d = Ex - Ey computed with an EXP_W+1-bit signed difference.
  - zero_d = (d == 0); sign_d = d[msb]; cmp = (Mx < My).
  - EOP = x[s]^y[s]^op.
  - Swap: the big operand is Y when sign_d, or when (zero_d & cmp); otherwise X.
  - shamt = |d|, saturated to MAN_W+3.
  - Special flags computed here.
- Stage 2:
  - m_small = ({m_small_raw, 3'b000} >> shamt).
  - S = OR of every bit shifted out below R, ORed into bit 0.
  - shamt >= MAN_W+3 ⇒ m_small = {0..0, S = (m_small_raw != 0)}.
  - All other fields are pipelined unchanged.
- Latency: 2 cycles from accept to out_valid when there is no backpressure; throughput 1 per cycle.
- Handshake:
  - Stage k advances when its successor is empty or being drained.
  - in_ready = !v1 | (!v2 | out_ready).
  - Outputs hold stable while out_valid & !out_ready.
  - No bubble is inserted on simultaneous fill and drain.
- Flag semantics are fixed for the downstream sign selector:
  - zero_d & !EOP ⇒ sign Sx.
  - zero_d & EOP ⇒ Sx^cmp.
  - !zero_d ⇒ sign_d ? Sy : Sx.
- Equal magnitudes under subtraction: cmp = 0, zero_d = 1; the downstream stage forces +0.
- A reset asserted mid-operation discards both stages immediately; no partial output.

Decomposition:
- Shared package fpu_pkg:
  - EXP_W and MAN_W defaults.
  - BIAS.
  - Field slice constants (sign bit, exponent and fraction ranges).
  - GRS width = 3.
- One sub-module, fpu_align_shifter: right shift with sticky collapse and saturation.
  - Combinational.
  - Parameterised by width.
  - Reused later by the FMA path.

Test Plan:
- Add 1.0 + 2.0 (x = 3F800000, y = 40000000, op = 0):
  - After 2 cycles: Sx = 0, Sy = 0, EOP = 0, zero_d = 0, sign_d = 1.
  - e_big = 0x80, m_big = 0x800000, m_small = {0x400000, GRS = 000}.
- Subtract 1.5 - 1.75 (3FC00000, 3FE00000, op = 1):
  - EOP = 0 relative to signs, since Sy = 1 ⇒ EOP = 1.
  - zero_d = 1, cmp = 1, big = Y.
- Sticky, 1.0 + 2^-30:
  - shamt = 30 ≥ 26 ⇒ m_small = 0…01 (S = 1); e_big = 0x7F.
- Backpressure:
  - Stream 4 operand pairs with out_ready low for 3 cycles.
  - in_ready drops after 2 accepted; outputs stay stable.
  - All 4 results emerge in order, none lost or duplicated.
- Specials:
  - +inf - +inf ⇒ is_nan = 1.
  - +inf + 1.0 ⇒ is_inf = 1, is_nan = 0.
  - Quiet NaN input ⇒ is_nan = 1.
- Reset mid-flight:
  - Assert rst_n low asynchronously between clock edges with v1 = v2 = 1.
  - out_valid = 0 immediately; after release, the first new result arrives 2 cycles after accept.
